// File: rtl/load_align_if.sv
// load_align_if: request, memory and response signals of the load-align unit
interface load_align_if #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32
);
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0] req_size;
  logic req_unsigned;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic rsp_err;
  logic rsp_split;
  modport slave (
    input req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err, rsp_split
  );
  modport master (
    output req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata, rsp_ready,
    input req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err, rsp_split
  );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: fetches, merges and sign/zero-extends aligned or boundary-crossing loads
module load_align_unit #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter bit ALLOW_MISALIGNED = 1
) (
  input logic clk,
  input logic rst_n,
  load_align_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  typedef enum logic [2:0] {IDLE, RD0, RD1, RESP, ERR} state_t;
  state_t state_q, state_d;
  logic [OB-1:0] off_q, off_d;
  logic [1:0] size_q, size_d;
  logic uns_q, uns_d, cross_q, cross_d;
  logic [XLEN-1:0] word0_q, word0_d, rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic rsp_err_q, rsp_err_d, rsp_split_q, rsp_split_d;
  logic req_cross, req_bad, sgn;
  logic [XLEN-1:0] w0, w1, sh, mask, ext;
  assign req_cross = int'(bus.req_addr[OB-1:0]) + (1 << bus.req_size) > NB;
  assign req_bad = (XLEN == 32 && bus.req_size == 2'd3) || (!ALLOW_MISALIGNED && req_cross);
  assign w0 = state_q == RD1 ? word0_q : bus.mem_rdata;
  assign w1 = state_q == RD1 ? bus.mem_rdata : {XLEN{1'b0}};
  assign sh = XLEN'({w1, w0} >> {off_q, 3'b000});
  assign mask = ~({XLEN{1'b1}} << (8 << size_q));
  assign sgn = !uns_q && |(sh & mask & ~(mask >> 1));
  assign ext = (sh & mask) | (sgn ? ~mask : {XLEN{1'b0}});
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_req = state_q == RD0 || state_q == RD1;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rsp_valid = state_q == RESP || state_q == ERR;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_split = rsp_split_q;
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    size_d = size_q;
    uns_d = uns_q;
    cross_d = cross_q;
    word0_d = word0_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    rsp_split_d = rsp_split_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        off_d = bus.req_addr[OB-1:0];
        size_d = bus.req_size;
        uns_d = bus.req_unsigned;
        cross_d = req_cross;
        mem_addr_d = {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
        rsp_data_d = '0;
        rsp_err_d = req_bad;
        rsp_split_d = 1'b0;
        state_d = req_bad ? ERR : RD0;
      end
      RD0: if (bus.mem_ack) begin
        word0_d = bus.mem_rdata;
        mem_addr_d = cross_q ? mem_addr_q + ADDR_W'(NB) : mem_addr_q;
        rsp_data_d = cross_q ? rsp_data_q : ext;
        state_d = cross_q ? RD1 : RESP;
      end
      RD1: if (bus.mem_ack) begin
        rsp_data_d = ext;
        rsp_split_d = 1'b1;
        state_d = RESP;
      end
      RESP, ERR: state_d = bus.rsp_ready ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      cross_q <= 1'b0;
      word0_q <= '0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      cross_q <= cross_d;
      word0_q <= word0_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      rsp_split_q <= rsp_split_d;
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: table, random and corner-case checks for load_align_unit
module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  load_align_if #(.XLEN(32), .ADDR_W(32)) a_if ();
  load_align_if #(.XLEN(32), .ADDR_W(32)) b_if ();
  load_align_if #(.XLEN(64), .ADDR_W(32)) c_if ();
  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  load_align_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  typedef struct {
    logic [31:0] addr;
    logic [1:0] size;
    logic uns;
    int wt;
    logic [31:0] data;
    logic split;
    int cyc;
  } vec_t;
  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  logic [7:0] mem8 [0:1023];
  int wait_a = 0;
  int cnt_a = 0;
  logic force_ack = 1'b0;
  logic [31:0] hold_a = '0;
  logic [31:0] addrs_a [$];
  logic [31:0] addrs_c [$];
  logic b_req_seen = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] wa);
    return {mem8[wa[9:0] + 10'd3], mem8[wa[9:0] + 10'd2], mem8[wa[9:0] + 10'd1], mem8[wa[9:0]]};
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size, input bit uns);
    logic [63:0] v = '0;
    int n = 1 << size;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem8[addr[9:0] + 10'(i)];
    if (!uns && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v[31:0];
  endfunction
  always @(negedge clk) begin
    a_if.mem_ack = 1'b0;
    if (force_ack) a_if.mem_ack = 1'b1;
    else if (a_if.mem_req) begin
      if (cnt_a == 0) hold_a = a_if.mem_addr;
      else chk("mem_addr_stable", a_if.mem_addr, hold_a);
      if (cnt_a >= wait_a) begin
        a_if.mem_ack = 1'b1;
        a_if.mem_rdata = word_at(a_if.mem_addr);
        addrs_a.push_back(a_if.mem_addr);
        cnt_a = 0;
      end else cnt_a++;
    end else cnt_a = 0;
  end
  always @(negedge clk) begin
    c_if.mem_ack = c_if.mem_req;
    c_if.mem_rdata = c_if.mem_addr == 32'h100 ? 64'h1122334455667788 :
                     c_if.mem_addr == 32'h108 ? 64'h99AABBCCDDEEFF00 : 64'h0;
    if (c_if.mem_req) addrs_c.push_back(c_if.mem_addr);
  end
  always @(negedge clk) if (b_if.mem_req) b_req_seen = 1'b1;
  task automatic run_a(input string nm, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                       input int wt, input logic [31:0] exp_data, input logic exp_split, input int exp_cyc);
    int cyc = 0;
    bit got = 0;
    wait_a = wt;
    addrs_a.delete();
    @(negedge clk);
    a_if.req_valid = 1'b1;
    a_if.req_addr = addr;
    a_if.req_size = size;
    a_if.req_unsigned = uns;
    @(posedge clk);
    #1;
    a_if.req_valid = 1'b0;
    a_if.req_addr = $urandom;
    a_if.req_size = 2'($urandom);
    a_if.req_unsigned = ~uns;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({nm, " req_ready_low"}, 64'(a_if.req_ready), 64'd0);
      got = a_if.rsp_valid;
    end
    chk({nm, " cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, " data"}, 64'(a_if.rsp_data), 64'(exp_data));
    chk({nm, " split"}, 64'(a_if.rsp_split), 64'(exp_split));
    chk({nm, " err"}, 64'(a_if.rsp_err), 64'd0);
    chk({nm, " nreads"}, 64'(addrs_a.size()), exp_split ? 64'd2 : 64'd1);
    if (addrs_a.size() > 0) chk({nm, " addr0"}, 64'(addrs_a[0]), 64'(addr & ~32'h3));
    if (addrs_a.size() > 1) chk({nm, " addr1"}, 64'(addrs_a[1]), 64'((addr & ~32'h3) + 32'h4));
    a_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_if.rsp_ready = 1'b0;
    chk({nm, " req_ready_back"}, 64'(a_if.req_ready), 64'd1);
  endtask
  task automatic run_b(input string nm, input logic [31:0] addr, input logic [1:0] size);
    @(negedge clk);
    b_if.req_valid = 1'b1;
    b_if.req_addr = addr;
    b_if.req_size = size;
    b_if.req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    b_if.req_valid = 1'b0;
    @(negedge clk);
    chk({nm, " rsp_valid_c1"}, 64'(b_if.rsp_valid), 64'd1);
    chk({nm, " err"}, 64'(b_if.rsp_err), 64'd1);
    chk({nm, " data"}, 64'(b_if.rsp_data), 64'd0);
    chk({nm, " split"}, 64'(b_if.rsp_split), 64'd0);
    @(negedge clk);
    chk({nm, " err_hold"}, 64'(b_if.rsp_valid & b_if.rsp_err), 64'd1);
    b_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b_if.rsp_ready = 1'b0;
    chk({nm, " req_ready_back"}, 64'(b_if.req_ready), 64'd1);
  endtask
  task automatic run_c(input string nm, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                       input logic [63:0] exp_data, input logic exp_split, input int exp_cyc, input int hold);
    int cyc = 0;
    bit got = 0;
    addrs_c.delete();
    @(negedge clk);
    c_if.req_valid = 1'b1;
    c_if.req_addr = addr;
    c_if.req_size = size;
    c_if.req_unsigned = uns;
    @(posedge clk);
    #1;
    c_if.req_valid = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = c_if.rsp_valid;
    end
    chk({nm, " cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, " data"}, c_if.rsp_data, exp_data);
    chk({nm, " split"}, 64'(c_if.rsp_split), 64'(exp_split));
    chk({nm, " nreads"}, 64'(addrs_c.size()), exp_split ? 64'd2 : 64'd1);
    if (addrs_c.size() > 0) chk({nm, " addr0"}, 64'(addrs_c[0]), 64'(addr & ~32'h7));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold_valid"}, 64'(c_if.rsp_valid), 64'd1);
      chk({nm, " hold_data"}, c_if.rsp_data, exp_data);
    end
    c_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    c_if.rsp_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] addr;
    logic [1:0] size;
    logic uns;
    int wt;
    logic split;
    int found;
    a_if.req_valid = 0; a_if.req_addr = 0; a_if.req_size = 0; a_if.req_unsigned = 0; a_if.rsp_ready = 0;
    a_if.mem_ack = 0; a_if.mem_rdata = 0;
    b_if.req_valid = 0; b_if.req_addr = 0; b_if.req_size = 0; b_if.req_unsigned = 0; b_if.rsp_ready = 0;
    b_if.mem_ack = 1; b_if.mem_rdata = '1;
    c_if.req_valid = 0; c_if.req_addr = 0; c_if.req_size = 0; c_if.req_unsigned = 0; c_if.rsp_ready = 0;
    c_if.mem_ack = 0; c_if.mem_rdata = 0;
    for (int i = 0; i < 1024; i++) mem8[i] = 8'($urandom);
    {mem8[259], mem8[258], mem8[257], mem8[256]} = 32'h8899AABB;
    {mem8[263], mem8[262], mem8[261], mem8[260]} = 32'h11223344;
    tbl[0] = '{32'h101, 2'd0, 1'b0, 0, 32'hFFFFFFAA, 1'b0, 2};
    tbl[1] = '{32'h101, 2'd0, 1'b1, 0, 32'h000000AA, 1'b0, 2};
    tbl[2] = '{32'h103, 2'd1, 1'b0, 0, 32'h00004488, 1'b1, 3};
    tbl[3] = '{32'h102, 2'd2, 1'b0, 2, 32'h33448899, 1'b1, 7};
    tbl[4] = '{32'h102, 2'd1, 1'b0, 0, 32'hFFFF8899, 1'b0, 2};
    tbl[5] = '{32'h100, 2'd2, 1'b1, 1, 32'h8899AABB, 1'b0, 3};
    tbl[6] = '{32'h101, 2'd1, 1'b1, 1, 32'h000099AA, 1'b0, 3};
    tbl[7] = '{32'h107, 2'd0, 1'b0, 2, 32'h00000011, 1'b0, 4};
    @(negedge clk);
    chk("reset req_ready", 64'(a_if.req_ready), 64'd1);
    chk("reset mem_req", 64'(a_if.mem_req), 64'd0);
    chk("reset mem_addr", 64'(a_if.mem_addr), 64'd0);
    chk("reset rsp_valid", 64'(a_if.rsp_valid), 64'd0);
    chk("reset rsp_data", 64'(a_if.rsp_data), 64'd0);
    chk("reset rsp_err_split", 64'({a_if.rsp_err, a_if.rsp_split}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run_a($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wt,
            tbl[i].data, tbl[i].split, tbl[i].cyc);
    for (int i = 0; i < 80; i++) begin
      addr = 32'h100 + $urandom_range(0, 512);
      size = 2'($urandom_range(0, 2));
      uns = 1'($urandom);
      wt = $urandom_range(0, 2);
      split = (int'(addr[1:0]) + (1 << size)) > 4;
      run_a($sformatf("rnd%0d", i), addr, size, uns, wt, ref_load(addr, int'(size), uns), split,
            split ? 3 + 2 * wt : 2 + wt);
    end
    wait_a = 3;
    @(negedge clk);
    a_if.req_valid = 1'b1;
    a_if.req_addr = 32'h103;
    a_if.req_size = 2'd1;
    a_if.req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    a_if.req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (a_if.mem_req && a_if.mem_addr == 32'h104) found = 1;
    end
    chk("rst reach_rd1", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst req_ready", 64'(a_if.req_ready), 64'd1);
    chk("rst mem_req", 64'(a_if.mem_req), 64'd0);
    chk("rst mem_addr", 64'(a_if.mem_addr), 64'd0);
    chk("rst rsp_valid", 64'(a_if.rsp_valid), 64'd0);
    chk("rst rsp_data", 64'(a_if.rsp_data), 64'd0);
    chk("rst rsp_err_split", 64'({a_if.rsp_err, a_if.rsp_split}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst stray_ack rsp_valid", 64'(a_if.rsp_valid), 64'd0);
      chk("rst stray_ack req_ready", 64'(a_if.req_ready), 64'd1);
    end
    force_ack = 1'b0;
    run_a("post_rst", 32'h103, 2'd1, 1'b0, 0, 32'h00004488, 1'b1, 3);
    run_b("err_lw_misaligned", 32'h102, 2'd2);
    run_b("err_size3", 32'h100, 2'd3);
    chk("err mem_req_never", 64'(b_req_seen), 64'd0);
    run_c("ld_unsigned", 32'h104, 2'd3, 1'b1, 64'hDDEEFF0011223344, 1'b1, 3, 3);
    if (addrs_c.size() > 1) chk("ld addr1", 64'(addrs_c[1]), 64'h108);
    run_c("ld_signed", 32'h104, 2'd3, 1'b0, 64'hDDEEFF0011223344, 1'b1, 3, 0);
    run_c("lw64_signed", 32'h108, 2'd2, 1'b0, 64'hFFFFFFFFDDEEFF00, 1'b0, 2, 0);
    run_c("lwu64_hi", 32'h10C, 2'd2, 1'b1, 64'h0000000099AABBCC, 1'b0, 2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
